// File: rtl/pp_seq_pkg.sv
// Shared types and default sizing for the ping-pong buffer sequencer.
package pp_seq_pkg;

   localparam int PP_SEQ_DEPTH        = 256;
   localparam int PP_SEQ_EARLY_MARGIN = 4;
   localparam int PP_SEQ_DATA_W       = 32;

   typedef enum logic {
      WR_RUN,
      WR_GAP
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_RUN,
      RD_WAIT
   } rd_state_t;

endpackage

// File: rtl/pp_seq_out_fifo.sv
// Two-entry {last,data} output FIFO for the sequencer read path.
// The writer is credit-managed by the sequencer, so there is no input ready;
// occupancy is exported so the sequencer can compute its issue credit.
module pp_seq_out_fifo
   import pp_seq_pkg::*;
#(
   parameter int DATA_W = PP_SEQ_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic [1:0]        count
);

   logic [DATA_W:0] mem [2];
   logic            wptr;
   logic            rptr;
   logic            pop;

   assign pop       = out_valid && out_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = out_valid ? mem[rptr][DATA_W-1:0] : '0;
   assign out_last  = out_valid && mem[rptr][DATA_W];

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else begin
         wptr  <= wptr ^ in_valid;
         rptr  <= rptr ^ pop;
         count <= count + {1'b0, in_valid} - {1'b0, pop};
      end
   end

   // Storage (not reset: contents only matter while counted as occupied)
   always_ff @(posedge clk) begin
      if (in_valid) mem[wptr] <= {in_last, in_data};
   end

endmodule

// File: rtl/pp_buffer_sequencer.sv
// Ping-pong buffer sequencer: streams input beats into the granted write
// block and streams the granted read block back out through a small FIFO.
// Optional feature macro: PP_SEQ_STALL_CNT_EN enables the stall cycle counter.
module pp_buffer_sequencer
   import pp_seq_pkg::*;
#(
   parameter  int DEPTH        = PP_SEQ_DEPTH,
   parameter  int EARLY_MARGIN = PP_SEQ_EARLY_MARGIN,
   parameter  int DATA_W       = PP_SEQ_DATA_W,
   localparam int ADDR_W       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        blk_0,
   input  logic [1:0]        blk_1,
   input  logic              stall_axi_b,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              wr_en0,
   output logic              wr_en1,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              rd_en0,
   output logic              rd_en1,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data0,
   input  logic [DATA_W-1:0] rd_data1,
   output logic              m_tvalid,
   output logic              m_tlast,
   output logic [DATA_W-1:0] m_tdata,
   input  logic              m_tready,
   output logic              done_wr,
   output logic              done_wr_early,
   output logic              done_rd,
   output logic              tlast_flag,
   output logic              err_sticky,
   output logic [15:0]       stall_cnt
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] EARLY_ADDR = ADDR_W'(DEPTH - 1 - EARLY_MARGIN);
   localparam logic [ADDR_W:0]   FULL_LEN   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   ONE_LEN    = (ADDR_W + 1)'(1);

   // ---------------- write side ----------------
   wr_state_t       wr_state, wr_state_nxt;
   logic            wr_avail, wr_sel, wr_accept, wr_end;
   logic [ADDR_W:0] len0, len1;

   assign wr_avail  = blk_0[0] | blk_1[0];
   assign wr_sel    = !blk_0[0];                 // block 0 wins when both are granted
   assign s_tready  = !rst && wr_avail && !stall_axi_b && (wr_state == WR_RUN);
   assign wr_accept = s_tready && s_tvalid;
   assign wr_end    = wr_accept && ((wr_addr == LAST_ADDR) || s_tlast);
   assign wr_en0    = wr_accept && !wr_sel;
   assign wr_en1    = wr_accept && wr_sel;

   // Write FSM state register
   always_ff @(posedge clk) begin
      if (rst) wr_state <= WR_RUN;
      else     wr_state <= wr_state_nxt;
   end

   // Write FSM next state: one idle cycle after each block so the grant update is seen
   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_RUN:  if (wr_end) wr_state_nxt = WR_GAP;
         WR_GAP:  wr_state_nxt = WR_RUN;
         default: wr_state_nxt = WR_RUN;
      endcase
   end

   // Write address, block length capture, write status pulses and error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr       <= '0;
         len0          <= FULL_LEN;
         len1          <= FULL_LEN;
         done_wr       <= 1'b0;
         done_wr_early <= 1'b0;
         tlast_flag    <= 1'b0;
         err_sticky    <= 1'b0;
      end else begin
         done_wr       <= wr_end;
         tlast_flag    <= wr_end && s_tlast;
         done_wr_early <= wr_accept && (wr_addr == EARLY_ADDR);
         if (blk_0[0] && blk_1[0]) err_sticky <= 1'b1;
         if (wr_accept) wr_addr <= wr_end ? '0 : wr_addr + ADDR_W'(1);
         if (wr_end && !wr_sel) len0 <= {1'b0, wr_addr} + ONE_LEN;
         if (wr_end &&  wr_sel) len1 <= {1'b0, wr_addr} + ONE_LEN;
      end
   end

   // ---------------- read side ----------------
   rd_state_t         rd_state, rd_state_nxt;
   logic              rd_blk, rd_abort, rd_grant, rd_issue, rd_drained, rd_done_now;
   logic [ADDR_W:0]   rd_len, rd_cnt;
   logic [2:0]        rd_held;
   logic [1:0]        fifo_cnt;
   logic              fifo_pop;
   logic              vld_p1, last_p1, blk_p1;
   logic [DATA_W-1:0] rd_word_p1;

   assign rd_grant    = rd_blk ? blk_1[1] : blk_0[1];
   assign fifo_pop    = m_tvalid && m_tready;
   // Words still owed to the FIFO once this cycle's pop is taken into account;
   // counting the pop is what allows one word per cycle at m_tready=1.
   assign rd_held     = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, fifo_pop};
   assign rd_issue    = !rst && (rd_state == RD_RUN) && !rd_abort && rd_grant &&
                        (rd_cnt < rd_len) && (rd_held < 3'd2);
   assign rd_en0      = rd_issue && !rd_blk;
   assign rd_en1      = rd_issue && rd_blk;
   assign rd_addr     = rd_cnt[ADDR_W-1:0];
   assign rd_drained  = (fifo_cnt == 2'd0) && !vld_p1;
   assign rd_done_now = (rd_state == RD_RUN) && !rd_abort && rd_grant && fifo_pop && m_tlast;
   assign rd_word_p1  = blk_p1 ? rd_data1 : rd_data0;

   // Read FSM state register
   always_ff @(posedge clk) begin
      if (rst) rd_state <= RD_IDLE;
      else     rd_state <= rd_state_nxt;
   end

   // Read FSM next state: start on any read grant, drain quietly if the grant is pulled
   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (blk_0[1] || blk_1[1]) rd_state_nxt = RD_RUN;
         RD_RUN: begin
            if (rd_abort || !rd_grant) begin
               if (rd_drained) rd_state_nxt = RD_IDLE;
            end else if (rd_done_now) begin
               rd_state_nxt = RD_WAIT;
            end
         end
         RD_WAIT: if (!rd_grant) rd_state_nxt = RD_IDLE;
         default: rd_state_nxt = RD_IDLE;
      endcase
   end

   // Read block selection, issue counter, abort flag and completion pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_blk   <= 1'b0;
         rd_len   <= FULL_LEN;
         rd_cnt   <= '0;
         rd_abort <= 1'b0;
         vld_p1   <= 1'b0;
         done_rd  <= 1'b0;
      end else begin
         done_rd <= rd_done_now;
         vld_p1  <= rd_issue;
         if (rd_state == RD_IDLE) begin
            rd_cnt   <= '0;
            rd_abort <= 1'b0;
            if (blk_0[1]) begin
               rd_blk <= 1'b0;
               rd_len <= len0;
            end else if (blk_1[1]) begin
               rd_blk <= 1'b1;
               rd_len <= len1;
            end
         end else begin
            if (rd_issue) rd_cnt <= rd_cnt + ONE_LEN;
            if ((rd_state == RD_RUN) && !rd_grant) rd_abort <= 1'b1;
         end
      end
   end

   // ---- stage p1: BRAM word returns one cycle after issue ----
   always_ff @(posedge clk) begin
      last_p1 <= (rd_cnt == rd_len - ONE_LEN);
      blk_p1  <= rd_blk;
   end

   pp_seq_out_fifo #(.DATA_W(DATA_W)) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld_p1),
      .in_data   (rd_word_p1),
      .in_last   (last_p1),
      .out_valid (m_tvalid),
      .out_data  (m_tdata),
      .out_last  (m_tlast),
      .out_ready (m_tready),
      .count     (fifo_cnt)
   );

`ifdef PP_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of cycles where the source is held off by the AXI-B stall
   always_ff @(posedge clk) begin
      if (rst)                                                        stall_cnt_q <= 16'h0;
      else if (s_tvalid && stall_axi_b && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'h1;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_pp_buffer_sequencer.sv
// Directed bench for pp_buffer_sequencer (DEPTH=16, EARLY_MARGIN=4) with a
// BRAM model and an output-word scoreboard.
module tb_pp_buffer_sequencer;

   localparam int DEPTH = 16;
   localparam int EM    = 4;
   localparam int DW    = 32;
   localparam int AW    = 4;
`ifdef PP_SEQ_STALL_CNT_EN
   localparam int STALL_EXP = 10;
`else
   localparam int STALL_EXP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    blk_0, blk_1;
   logic          stall_axi_b, s_tvalid, s_tlast, s_tready;
   logic [DW-1:0] s_tdata;
   logic          wr_en0, wr_en1, rd_en0, rd_en1;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] rd_data0, rd_data1;
   logic          m_tvalid, m_tlast, m_tready;
   logic [DW-1:0] m_tdata;
   logic          done_wr, done_wr_early, done_rd, tlast_flag, err_sticky;
   logic [15:0]   stall_cnt;

   int checks = 0;
   int errors = 0;

   logic [DW:0]   sb_q [$];
   logic [DW-1:0] mem0 [DEPTH];
   logic [DW-1:0] mem1 [DEPTH];

   always #5 clk = ~clk;

   pp_buffer_sequencer #(.DEPTH(DEPTH), .EARLY_MARGIN(EM), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .blk_0(blk_0), .blk_1(blk_1), .stall_axi_b(stall_axi_b),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .wr_en0(wr_en0), .wr_en1(wr_en1), .wr_addr(wr_addr),
      .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_addr(rd_addr),
      .rd_data0(rd_data0), .rd_data1(rd_data1),
      .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
      .done_wr(done_wr), .done_wr_early(done_wr_early), .done_rd(done_rd),
      .tlast_flag(tlast_flag), .err_sticky(err_sticky), .stall_cnt(stall_cnt)
   );

   // External BRAM pair: write-through on wr_enN, 1-cycle read latency
   always @(posedge clk) begin
      if (wr_en0) mem0[wr_addr] <= s_tdata;
      if (wr_en1) mem1[wr_addr] <= s_tdata;
      if (rd_en0) rd_data0 <= mem0[rd_addr];
      if (rd_en1) rd_data1 <= mem1[rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input int b, input int i);
      return 32'hC0DE_0000 + 32'(b * 256) + 32'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_block(input int b, input int n);
      for (int i = 0; i < n; i++) sb_q.push_back({(i == n - 1), word(b, i)});
   endtask

   // Drive n write beats to block b; checks strobe, address and early pulse per beat
   task automatic wr_beats(input int b, input int n, input int tlast_at, input int early_at,
                           input bit toggle);
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = word(b, i);
         s_tlast  = (i == tlast_at);
         if (toggle) m_tready = ~m_tready;
         @(negedge clk);
         chk("wr_en_sel",   (b == 0) ? wr_en0 : wr_en1, 1);
         chk("wr_en_other", (b == 0) ? wr_en1 : wr_en0, 0);
         chk("wr_addr",     wr_addr, i);
         chk("early_pulse", done_wr_early, (i == early_at));
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input string tag, input int bound, input bit toggle);
      int k = 0;
      while (sb_q.size() != 0 && k < bound) begin
         tick();
         if (toggle) m_tready = ~m_tready;
         k++;
      end
      chk(tag, sb_q.size(), 0);
   endtask

   // Output monitor: scoreboard pop, done_rd timing, outstanding-read bound
   int   issued = 0, popped = 0, max_out = 0;
   logic prev_last_hs = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         prev_last_hs = 1'b0;
      end else begin
         if (done_rd || prev_last_hs) chk("done_rd_timing", done_rd, prev_last_hs);
         if (m_tvalid && m_tready) begin
            if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
            else chk("m_word", {m_tlast, m_tdata}, sb_q.pop_front());
         end
         prev_last_hs = m_tvalid && m_tready && m_tlast;
         issued += int'(rd_en0 | rd_en1);
         popped += int'(m_tvalid && m_tready);
         if (issued - popped > max_out) max_out = issued - popped;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; blk_0 = 2'b01; blk_1 = 2'b00; stall_axi_b = 1'b0;
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;

      // reset state
      tick();
      @(negedge clk);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_wr_en0",   wr_en0, 0);
      chk("rst_wr_addr",  wr_addr, 0);
      chk("rst_rd_addr",  rd_addr, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata",  m_tdata, 0);
      chk("rst_done_wr",  done_wr, 0);
      chk("rst_done_rd",  done_rd, 0);
      chk("rst_err",      err_sticky, 0);
      chk("rst_stall",    stall_cnt, 0);
      tick();
      rst = 1'b0;

      // full 16-beat write into block 0
      wr_beats(0, 16, -1, 12, 1'b0);
      @(negedge clk);
      chk("a_done_wr",    done_wr, 1);
      chk("a_tlast_flag", tlast_flag, 0);
      chk("a_early",      done_wr_early, 0);
      chk("a_gap_ready",  s_tready, 0);
      tick();
      blk_0 = 2'b00;

      // read block 0 at full rate
      tick();
      blk_0 = 2'b10; m_tready = 1'b1;
      push_block(0, 16);
      k = 0;
      @(negedge clk);
      while (!m_tvalid && k < 20) begin @(negedge clk); k++; end
      chk("c_first_valid", m_tvalid, 1);
      for (int i = 0; i < 16; i++) begin
         chk("c_stream_valid", m_tvalid, 1);
         chk("c_stream_last",  m_tlast, (i == 15));
         @(negedge clk);
      end
      chk("c_done_rd",  done_rd, 1);
      chk("c_idle_out", m_tvalid, 0);
      tick();
      blk_0 = 2'b00;
      tick();

      // concurrent: re-read block 0 with toggling ready while block 1 gets a short write
      blk_0 = 2'b10; blk_1 = 2'b01; m_tready = 1'b1;
      push_block(0, 16);
      wr_beats(1, 6, 5, -1, 1'b1);
      @(negedge clk);
      chk("b_done_wr",    done_wr, 1);
      chk("b_tlast_flag", tlast_flag, 1);
      chk("b_early",      done_wr_early, 0);
      tick();
      blk_1 = 2'b00;
      drain("d_drain_toggle", 120, 1'b1);
      tick();
      m_tready = 1'b1;

      // read block 1 (length 6 from the tlast-terminated write)
      blk_0 = 2'b00; blk_1 = 2'b10;
      push_block(1, 6);
      drain("e_drain_blk1", 40, 1'b0);
      tick();
      tick();
      blk_1 = 2'b00;
      tick();

      // read grant withdrawn mid-block: only the words already requested drain
      blk_0 = 2'b10; m_tready = 1'b0;
      sb_q.push_back({1'b0, word(0, 0)});
      sb_q.push_back({1'b0, word(0, 1)});
      for (int i = 0; i < 6; i++) tick();
      blk_0 = 2'b00; m_tready = 1'b1;
      drain("f_abort_drain", 20, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      chk("f_abort_quiet", m_tvalid, 0);
      blk_0 = 2'b10;
      push_block(0, 16);
      drain("f_reread", 60, 1'b0);
      tick();
      tick();
      blk_0 = 2'b00;
      tick();

      // stall: source held off, counter behaviour depends on the build
      blk_0 = 2'b01; stall_axi_b = 1'b1; s_tvalid = 1'b1; s_tdata = word(2, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("g_stall_ready", s_tready, 0);
         chk("g_stall_wr_en", wr_en0, 0);
         tick();
      end
      s_tvalid = 1'b0; stall_axi_b = 1'b0;
      @(negedge clk);
      chk("g_stall_cnt", stall_cnt, STALL_EXP);
      tick();

      // both write grants: block 0 used, error latched
      blk_1 = 2'b01; s_tvalid = 1'b1; s_tdata = word(3, 0);
      @(negedge clk);
      chk("h_both_wr0", wr_en0, 1);
      chk("h_both_wr1", wr_en1, 0);
      tick();
      blk_1 = 2'b00; s_tvalid = 1'b0;
      @(negedge clk);
      chk("h_err_set", err_sticky, 1);
      tick();
      tick();
      @(negedge clk);
      chk("h_err_hold", err_sticky, 1);
      tick();

      // reset mid-block
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("i_err_clr",  err_sticky, 0);
      chk("i_addr_clr", wr_addr, 0);
      tick();
      wr_beats(0, 7, -1, -1, 1'b0);
      rst = 1'b1; s_tvalid = 1'b1; s_tdata = word(0, 7);
      @(negedge clk);
      chk("i_rst_ready", s_tready, 0);
      chk("i_rst_wr_en", wr_en0, 0);
      chk("i_rst_rd_en", rd_en0, 0);
      tick();
      @(negedge clk);
      chk("i_rst_done_wr", done_wr, 0);
      chk("i_rst_early",   done_wr_early, 0);
      chk("i_rst_tlast",   tlast_flag, 0);
      chk("i_rst_addr",    wr_addr, 0);
      chk("i_rst_mvalid",  m_tvalid, 0);
      tick();
      rst = 1'b0;
      wr_beats(0, 16, -1, 12, 1'b0);
      @(negedge clk);
      chk("i_restart_done", done_wr, 1);
      tick();

      chk("credit_max", (max_out <= 2), 1);
      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
